key_logic_lab: RTL and testbench
================================

// Module: key_logic_lab
// PURPOSE
//  Parametrised key-to-LED logic lab: synchronises and debounces w_key push-buttons,
//  evaluates a switch-selected reduction (AND/OR/XOR/NAND) over all keys, shows
//  gate-only XOR and De Morgan checks, and counts presses. Level or toggle operand mode.
//  Sits inside top between board key/sw inputs and led output.
// PARAMETERS
//  w_key            4       number of keys (>= 2)
//  w_sw             8       switch width (>= 3; sw[2:0] used)
//  w_led            8       LED width (>= 5)
//  debounce_cycles  500000  stable cycles before accepting key change (10 ms @ 50 MHz; >= 2)
// PORTS
//  clk          in   1        single clock
//  rst          in   1        reset, asynchronous, active-low
//  key          in   w_key    raw key inputs, active-high (pressed = 1), asynchronous
//  sw           in   w_sw     sw[1:0] op select, sw[2] mode (0 level, 1 toggle); asynchronous
//  led          out  w_led    registered results, see BEHAVIOUR
//  key_pressed  out  w_key    one-cycle pulse per key on accepted 0->1 transition
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. While rst=0 all flops clear
//   immediately: sync stages, stable, counters, toggle bits, led=0, key_pressed=0.
//   Reset mid-debounce or mid-count discards progress; no pulse after release of rst.
//  Sync: key and sw[2:0] each pass 2 flops (reset 0) -> ks, ss.
//  Debounce (per key i): cnt_i width $clog2(debounce_cycles+1).
//   ks[i]==stable[i] -> cnt_i<=0. ks[i]!=stable[i] -> cnt_i++; when cnt_i==debounce_cycles-1
//   stable[i]<=ks[i], cnt_i<=0. Glitch shorter than debounce_cycles never changes stable.
//  key_pressed[i]=1 for exactly the cycle after stable[i] goes 0->1 (registered). Release: no pulse.
//  Operand v: ss[2]=0 -> v=stable. ss[2]=1 -> v=tog; tog[i] flips on each key_pressed[i].
//   tog keeps updating in level mode; mode change never clears tog.
//  led[0] = reduce(v): ss[1:0] 00 &v, 01 |v, 10 ^v, 11 ~&v.
//  led[1] = (v[0]|v[1]) & ~(v[0]&v[1]), built only from &,|,~.
//  led[2] = De Morgan check: (~(v0&v1)==(~v0|~v1)) & (~(v0|v1)==(~v0&~v1)); 1 after reset exit.
//  led[3] = led[1] ^ (v[0]^v[1]); mismatch flag, must stay 0.
//  led[w_led-1:4] = press_cnt, adds popcount(key_pressed) each cycle, wraps mod 2^(w_led-4).
//  All led bits registered: led reflects v/ss of previous cycle.
//  Latency: key edge -> stable 2+debounce_cycles cycles; stable -> led +1; -> key_pressed +1.
//  Simultaneous presses: independent per key; two in same cycle -> press_cnt += 2.
//  led[2] reads 0 only during reset (flops clear); goes 1 first clock after rst deasserts.
// TESTING (bench uses debounce_cycles=4, w_key=4, w_led=8)
//  1 rst=0 mid-operation, keys held -> led=0,key_pressed=0 immediately; after release, pulses
//    only after full re-debounce of held keys.
//  2 sw=000, key=0011 held 10 cycles -> led[0]=0; key=1111 -> led[0]=1 after 2+4+1 cycles.
//  3 sw=010, key[0] bounce 1-0-1 with 2-cycle highs, then steady 1 -> single key_pressed[0],
//    led[0]=1, led[1]=1, led[3]=0, led[7:4]=1.
//  4 sw=100 (toggle), press/release key[1] twice -> tog[1] 0->1->0; sw=101 after first press
//    -> led[0]=1; press_cnt=2.
//  5 keys 0 and 2 accepted same cycle -> both pulses same cycle, led[7:4] += 2;
//    16 total presses -> led[7:4] wraps to 0.
//  6 Exhaustive v[1:0] in 00..11, every sw[1:0] -> led[0] matches reduction,
//    led[2]=1, led[3]=0 always.

Source files
------------

// File: rtl/key_logic_lab.sv
`default_nettype none
// ============================================================================
// Module      : key_logic_lab
// Description : Synchronised, debounced push-buttons driving a switch-selected
//               reduction, gate-level XOR / De Morgan checks and a press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module key_logic_lab #(
    parameter int W_KEY           = 4,
    parameter int W_SW            = 8,
    parameter int W_LED           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_KEY-1:0] key,
    input  logic [W_SW-1:0]  sw,
    output logic [W_LED-1:0] led,
    output logic [W_KEY-1:0] key_pressed
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                 c_pc_w     = W_LED - 4;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [W_KEY-1:0]   r_key_s1;
    logic [W_KEY-1:0]   r_key_s2;
    logic [2:0]         r_sw_s1;
    logic [2:0]         r_sw_s2;
    logic [c_cnt_w-1:0] r_cnt [W_KEY];
    logic [W_KEY-1:0]   r_stable;
    logic [W_KEY-1:0]   r_stable_d;
    logic [W_KEY-1:0]   r_key_pressed;
    logic [W_KEY-1:0]   r_tog;
    logic [c_pc_w-1:0]  r_press_cnt;
    logic [3:0]         r_flags;

    logic [W_KEY-1:0]   w_v;
    logic               w_reduce;
    logic               w_xor_gate;
    logic               w_demorgan;
    logic               w_mismatch;
    logic [c_pc_w-1:0]  w_press_sum;
    logic               w_unused_sw;

    // Only sw[2:0] carry meaning; the upper switches are deliberately ignored.
    assign w_unused_sw = ^sw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw[2:0];
            r_sw_s2  <= r_sw_s1;
        end
    end

    // A key is accepted once its synchronised level disagrees with the
    // accepted level for DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < W_KEY; i++) begin
                r_cnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < W_KEY; i++) begin
                if (r_key_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    r_stable[i] <= r_key_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end
            end
        end
    end

    always_comb begin
        w_press_sum = '0;
        for (int i = 0; i < W_KEY; i++) begin
            w_press_sum = w_press_sum + c_pc_w'(r_key_pressed[i]);
        end
    end

    assign w_v = r_sw_s2[2] ? r_tog : r_stable;

    always_comb begin
        case (r_sw_s2[1:0])
            2'b00:   w_reduce = &w_v;
            2'b01:   w_reduce = |w_v;
            2'b10:   w_reduce = ^w_v;
            default: w_reduce = ~&w_v;
        endcase
    end

    assign w_xor_gate = (w_v[0] | w_v[1]) & ~(w_v[0] & w_v[1]);
    assign w_demorgan = ((~(w_v[0] & w_v[1])) == (~w_v[0] | ~w_v[1])) &
                        ((~(w_v[0] | w_v[1])) == (~w_v[0] & ~w_v[1]));
    assign w_mismatch = w_xor_gate ^ (w_v[0] ^ w_v[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d    <= '0;
            r_key_pressed <= '0;
            r_tog         <= '0;
            r_press_cnt   <= '0;
            r_flags       <= '0;
        end else begin
            r_stable_d    <= r_stable;
            r_key_pressed <= r_stable & ~r_stable_d;
            r_tog         <= r_tog ^ r_key_pressed;
            r_press_cnt   <= r_press_cnt + w_press_sum;
            r_flags       <= {w_mismatch, w_demorgan, w_xor_gate, w_reduce};
        end
    end

    assign led         = {r_press_cnt, r_flags};
    assign key_pressed = r_key_pressed;

endmodule
`default_nettype wire

// File: tb/tb_key_logic_lab.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_logic_lab
// Description : Randomised and directed self-checking bench for key_logic_lab.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_logic_lab;

    localparam int W_KEY = 4;
    localparam int W_SW  = 8;
    localparam int W_LED = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W_KEY-1:0] key = '0;
    logic [W_SW-1:0]  sw  = '0;
    logic [W_LED-1:0] led;
    logic [W_KEY-1:0] key_pressed;

    int n_checks = 0;
    int n_errors = 0;

    key_logic_lab #(
        .W_KEY(W_KEY),
        .W_SW(W_SW),
        .W_LED(W_LED),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .sw(sw),
        .led(led),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Reference model: raw input histories, accepted levels and counters.
    logic [3:0] key_h[$];
    logic [2:0] sw_h[$];
    logic [3:0] m_stable;
    logic [3:0] m_rose;
    logic [3:0] m_kp;
    logic [3:0] m_tog;
    logic [3:0] m_cnt;
    logic [7:0] m_led;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        key_h = {};
        sw_h  = {};
        for (int j = 0; j <= DEB; j++) begin
            key_h.push_back(4'd0);
            sw_h.push_back(3'd0);
        end
        m_stable = '0;
        m_rose   = '0;
        m_kp     = '0;
        m_tog    = '0;
        m_cnt    = '0;
        m_led    = '0;
    endtask

    // One clock of behaviour: history index 0 is the previous clock's sample,
    // so index 1 is what the design sees after two synchroniser stages.
    task automatic m_update();
        logic [3:0] v;
        logic [2:0] ss;
        logic [3:0] flags;
        logic       flip;
        ss = sw_h[1];
        v  = ss[2] ? m_tog : m_stable;
        case (ss[1:0])
            2'd0:    flags[0] = (v == 4'hF);
            2'd1:    flags[0] = (v != 4'h0);
            2'd2:    flags[0] = (($countones(v) % 2) == 1);
            default: flags[0] = (v != 4'hF);
        endcase
        flags[1] = (v[0] != v[1]);
        flags[2] = 1'b1;
        flags[3] = 1'b0;
        m_cnt = m_cnt + 4'($countones(m_kp));
        m_tog = m_tog ^ m_kp;
        m_kp  = m_rose;
        m_rose = '0;
        for (int i = 0; i < W_KEY; i++) begin
            flip = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (key_h[j][i] == m_stable[i]) flip = 1'b0;
            end
            if (flip) begin
                m_stable[i] = ~m_stable[i];
                m_rose[i]   = m_stable[i];
            end
        end
        m_led = {m_cnt, flags};
        key_h.push_front(key);
        void'(key_h.pop_back());
        sw_h.push_front(sw[2:0]);
        void'(sw_h.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_update();
        #1;
        check_val("led_model", {24'd0, led}, {24'd0, m_led});
        check_val("kp_model", {28'd0, key_pressed}, {28'd0, m_kp});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        m_clear();
        check_val("rst_led", {24'd0, led}, 32'd0);
        check_val("rst_kp", {28'd0, key_pressed}, 32'd0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int pulses;
        logic exp0;
        logic [3:0] v;

        #2;
        apply_reset();

        // Partial AND, then full AND after sync + debounce + register.
        sw  = 8'b000;
        key = 4'b0011;
        run(10);
        check_val("s2_and_partial", {31'd0, led[0]}, 32'd0);
        key = 4'b1111;
        run(6);
        check_val("s2_and_early", {31'd0, led[0]}, 32'd0);
        step();
        check_val("s2_and_all", {31'd0, led[0]}, 32'd1);
        check_val("s2_demorgan", {31'd0, led[2]}, 32'd1);

        // Reset mid-operation with keys held: full re-debounce before pulses.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("s1_no_pulse", {28'd0, key_pressed}, 32'd0);
        end
        step();
        check_val("s1_pulse", {28'd0, key_pressed}, 32'hF);

        // Bounce on key 0 in XOR mode.
        key = 4'b0000;
        sw  = 8'b010;
        apply_reset();
        pulses = 0;
        key = 4'b0001; run(2); pulses += int'(key_pressed[0]);
        key = 4'b0000; run(2); pulses += int'(key_pressed[0]);
        key = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            pulses += int'(key_pressed[0]);
        end
        check_val("s3_single_pulse", pulses, 32'd1);
        check_val("s3_xor", {31'd0, led[0]}, 32'd1);
        check_val("s3_gate_xor", {31'd0, led[1]}, 32'd1);
        check_val("s3_mismatch", {31'd0, led[3]}, 32'd0);
        check_val("s3_cnt", {28'd0, led[7:4]}, 32'd1);

        // Toggle mode on key 1.
        key = 4'b0000;
        apply_reset();
        sw  = 8'b100;
        key = 4'b0010; run(8);
        sw  = 8'b101; run(4);
        check_val("s4_tog_on", {31'd0, led[0]}, 32'd1);
        key = 4'b0000; run(8);
        key = 4'b0010; run(8);
        key = 4'b0000; run(8);
        check_val("s4_tog_off", {31'd0, led[0]}, 32'd0);
        check_val("s4_cnt", {28'd0, led[7:4]}, 32'd2);

        // Simultaneous presses and counter wrap.
        apply_reset();
        sw  = 8'b000;
        key = 4'b0101;
        run(6);
        step();
        check_val("s5_same_cycle", {28'd0, key_pressed}, 32'h5);
        step();
        check_val("s5_cnt2", {28'd0, led[7:4]}, 32'd2);
        key = 4'b0000; run(8);
        for (int r = 0; r < 7; r++) begin
            key = 4'b0101; run(8);
            key = 4'b0000; run(8);
        end
        check_val("s5_wrap", {28'd0, led[7:4]}, 32'd0);

        // Every operand pattern under every reduction.
        for (int vi = 0; vi < 16; vi++) begin
            v   = 4'(vi);
            key = v;
            run(8);
            for (int op = 0; op < 4; op++) begin
                sw = 8'(op);
                run(4);
                case (op)
                    0:       exp0 = (v == 4'hF);
                    1:       exp0 = (v != 4'h0);
                    2:       exp0 = (($countones(v) % 2) == 1);
                    default: exp0 = (v != 4'hF);
                endcase
                check_val("s6_reduce", {31'd0, led[0]}, {31'd0, exp0});
                check_val("s6_xor", {31'd0, led[1]}, {31'd0, v[0] ^ v[1]});
                check_val("s6_demorgan", {31'd0, led[2]}, 32'd1);
                check_val("s6_mismatch", {31'd0, led[3]}, 32'd0);
            end
        end

        // Random key/switch activity, with one reset in the middle.
        for (int s = 0; s < 120; s++) begin
            if (s == 60) apply_reset();
            key = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            run($urandom_range(1, 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
